// File: rtl/serial_pattern_source.sv
// Parallel-to-serial word source feeding the sequence detector.
// One-word holding register lets back-to-back words stream with no idle gap.
module serial_pattern_source #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             load,
   output logic             ready,
   output logic             x,
   output logic             busy,
   output logic             done,
   output logic [7:0]       word_count
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

   typedef enum logic {StIdle, StShift} state_e;

   state_e           state;
   logic [WIDTH-1:0] hold;
   logic             hold_valid;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    bit_cnt;

   logic             accept;
   logic             last_bit;
   logic [WIDTH-1:0] sreg_shifted;

   always_comb begin
      accept   = load & ~hold_valid;
      last_bit = (state == StShift) && (bit_cnt == LastBit);
      if (MSB_FIRST) begin
         sreg_shifted = sreg << 1;
      end else begin
         sreg_shifted = sreg >> 1;
      end
   end

   // accept needs hold_valid=0 and every transfer needs hold_valid=1, so they never collide
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= StIdle;
         hold       <= '0;
         hold_valid <= 1'b0;
         sreg       <= '0;
         bit_cnt    <= '0;
         word_count <= '0;
      end else begin
         if (accept) begin
            hold       <= din;
            hold_valid <= 1'b1;
         end
         unique case (state)
            StIdle: begin
               if (hold_valid) begin
                  sreg       <= hold;
                  bit_cnt    <= '0;
                  hold_valid <= 1'b0;
                  state      <= StShift;
               end
            end
            StShift: begin
               if (last_bit) begin
                  word_count <= word_count + 8'd1;
                  bit_cnt    <= '0;
                  if (hold_valid) begin
                     sreg       <= hold;
                     hold_valid <= 1'b0;
                  end else begin
                     sreg  <= sreg_shifted;
                     state <= StIdle;
                  end
               end else begin
                  sreg    <= sreg_shifted;
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   always_comb begin
      ready = ~hold_valid;
      busy  = (state == StShift);
      done  = last_bit;
      if (state == StShift) begin
         x = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
      end else begin
         x = IDLE_BIT;
      end
   end

endmodule

// File: tb/tb_serial_pattern_source.sv
// Bench for serial_pattern_source: word-level model checked every cycle on two
// instances (MSB-first/idle 0 and LSB-first/idle 1), plus literal directed cases.
module tb_serial_pattern_source;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] din;
   logic       load;

   logic       ready_m, x_m, busy_m, done_m;
   logic [7:0] wc_m;
   logic       ready_l, x_l, busy_l, done_l;
   logic [7:0] wc_l;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   serial_pattern_source #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
      .clk(clk), .reset(reset), .din(din), .load(load),
      .ready(ready_m), .x(x_m), .busy(busy_m), .done(done_m), .word_count(wc_m)
   );

   serial_pattern_source #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
      .clk(clk), .reset(reset), .din(din), .load(load),
      .ready(ready_l), .x(x_l), .busy(busy_l), .done(done_l), .word_count(wc_l)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Word-level model: current word plus bit position, one pending word, finished-word count.
   bit       m_active;
   bit [7:0] m_word;
   int       m_idx;
   bit       m_hv;
   bit [7:0] m_hold;
   bit [7:0] m_cnt;

   always @(posedge clk) begin
      bit acc;
      if (reset) begin
         m_active = 0; m_idx = 0; m_hv = 0; m_cnt = 0;
      end else begin
         acc = load && !m_hv;
         if (m_active) begin
            if (m_idx == 7) begin
               m_cnt = m_cnt + 8'd1;
               if (m_hv) begin
                  m_word = m_hold; m_idx = 0; m_hv = 0;
               end else begin
                  m_active = 0;
               end
            end else begin
               m_idx++;
            end
         end else if (m_hv) begin
            m_active = 1; m_word = m_hold; m_idx = 0; m_hv = 0;
         end
         if (acc) begin
            m_hold = din; m_hv = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_x", x_m, m_active ? m_word[7-m_idx] : 1'b0);
         check("l_x", x_l, m_active ? m_word[m_idx] : 1'b1);
         check("m_busy", busy_m, m_active);
         check("l_busy", busy_l, m_active);
         check("m_done", done_m, m_active && m_idx == 7);
         check("l_done", done_l, m_active && m_idx == 7);
         check("m_ready", ready_m, !m_hv);
         check("l_ready", ready_l, !m_hv);
         check("m_wc", wc_m, m_cnt);
         check("l_wc", wc_l, m_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; load = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0]  gm, gl, gd;
      logic [15:0] gm16, gl16, gd16, el16;
      logic [7:0]  w;
      int busyc, gaps, ndone;
      bit started, pend255, pend256;

      reset = 1'b1; load = 1'b0; din = '0;
      tick();
      reset = 1'b0;
      chk_en = 1'b1;

      // Reset state
      check("rst_x_m", x_m, 1'b0);
      check("rst_x_l", x_l, 1'b1);
      check("rst_ready", ready_m, 1'b1);
      check("rst_busy", busy_m, 1'b0);
      check("rst_done", done_m, 1'b0);
      check("rst_wc", wc_m, 8'd0);

      // Single word A5
      load = 1'b1; din = 8'hA5;
      tick();
      load = 1'b0;
      check("a5_gap_busy", busy_m, 1'b0);
      check("a5_gap_x", x_m, 1'b0);
      tick();
      busyc = 0;
      for (int i = 0; i < 8; i++) begin
         gm[7-i] = x_m; gl[i] = x_l; gd[i] = done_m;
         if (busy_m) busyc++;
         tick();
      end
      check("a5_bits_msb", gm, 8'hA5);
      check("a5_bits_lsb", gl, 8'hA5);
      check("a5_done", gd, 8'h80);
      check("a5_busy_cycles", busyc, 8);
      check("a5_after_x", x_m, 1'b0);
      check("a5_after_busy", busy_m, 1'b0);
      check("a5_wc", wc_m, 8'd1);

      // Streamed A5, 3C, with FF offered while the 3C is still pending
      do_reset();
      load = 1'b1; din = 8'hA5;
      tick();
      load = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         gm16[15-i] = x_m; gl16[i] = x_l; gd16[i] = done_m;
         if (i == 0) begin
            load = 1'b1; din = 8'h3C;
         end else if (i <= 6) begin
            load = 1'b1; din = 8'hFF;
         end else begin
            load = 1'b0;
         end
         tick();
      end
      for (int i = 0; i < 16; i++) begin
         w = (i < 8) ? 8'hA5 : 8'h3C;
         el16[i] = w[i%8];
      end
      check("stream_bits_msb", gm16, 16'hA53C);
      check("stream_bits_lsb", gl16, el16);
      check("stream_done", gd16, 16'h8080);
      check("stream_wc", wc_m, 8'd2);
      check("stream_idle", busy_m, 1'b0);

      // Reset mid-word with a pending word
      do_reset();
      load = 1'b1; din = 8'hA5;
      tick();
      load = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         load = (i == 0); din = 8'h3C;
         tick();
      end
      load = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_x_m", x_m, 1'b0);
      check("mid_rst_x_l", x_l, 1'b1);
      check("mid_rst_busy", busy_m, 1'b0);
      check("mid_rst_ready", ready_m, 1'b1);
      check("mid_rst_wc", wc_m, 8'd0);
      busyc = 0;
      for (int i = 0; i < 10; i++) begin
         if (busy_m) busyc++;
         tick();
      end
      check("mid_rst_no_bits", busyc, 0);

      // Word 01: LSB-first gives 1 then seven 0s
      load = 1'b1; din = 8'h01;
      tick();
      load = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         gm[7-i] = x_m; gl[i] = x_l;
         tick();
      end
      check("w01_lsb", gl, 8'h01);
      check("w01_msb", gm, 8'h01);

      // Randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(99) == 0);
         load  = $urandom_range(1);
         din   = 8'($urandom);
         tick();
      end

      // 256 back-to-back words: count wrap and no gaps
      do_reset();
      load = 1'b1;
      started = 0; gaps = 0; ndone = 0; busyc = 0; pend255 = 0; pend256 = 0;
      for (int c = 0; c < 2300; c++) begin
         din = 8'($urandom);
         tick();
         if (pend256) begin
            check("wrap_wc0", wc_m, 8'd0);
            pend256 = 0;
            break;
         end
         if (pend255) begin
            check("wrap_wc255", wc_m, 8'd255);
            pend255 = 0;
         end
         if (busy_m) begin
            started = 1; busyc++;
         end else if (started) begin
            gaps++;
         end
         if (done_m) begin
            ndone++;
            if (ndone == 255) begin
               pend255 = 1; load = 1'b0;
            end
            if (ndone == 256) pend256 = 1;
         end
      end
      load = 1'b0;
      check("wrap_words", ndone, 256);
      check("wrap_gaps", gaps, 0);
      check("wrap_busy_cycles", busyc, 2048);

      tick();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
